// File: rtl/alu_addr_seq.sv
// Multi-cycle 16-bit effective-address sequencer (base + offset) on the shared 8-bit ALU.
// Optional ALU_SEQ_FORCE_HI_EN: always run the high-byte cycle (fixed 3-cycle timing).
`ifndef ALU_ADD
`define ALU_ADD 3'b000
`endif

module alu_addr_seq #(
  parameter logic [2:0] ADD_OP = `ALU_ADD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_base,
  input  logic [7:0]  req_off,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_addr,
  output logic        resp_cross,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [7:0]  alu_ai,
  output logic [7:0]  alu_bi,
  output logic        alu_ci,
  output logic [2:0]  alu_op,
  input  logic [7:0]  alu_out,
  input  logic        alu_c
);

`ifdef ALU_SEQ_FORCE_HI_EN
  localparam bit FORCE_HI = 1'b1;
`else
  localparam bit FORCE_HI = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [15:0] r_base;
  logic [7:0]  r_off;
  logic        r_signed;
  logic [7:0]  r_lo;
  logic        r_c;
  logic [15:0] r_addr;
  logic        r_cross;

  logic w_neg, w_fix_lo, w_fix, w_inc, w_dec, w_to_hi;

  // A negative displacement's carry is inverted: no carry means borrow from the high byte.
  assign w_neg    = r_signed & r_off[7];
  assign w_fix_lo = w_neg ? ~alu_c : alu_c;
  assign w_fix    = w_neg ? ~r_c : r_c;
  assign w_inc    = w_fix & ~w_neg;
  assign w_dec    = w_fix & w_neg;
  assign w_to_hi  = w_fix_lo | FORCE_HI;

  assign alu_op     = ADD_OP;
  assign resp_addr  = r_addr;
  assign resp_cross = r_cross;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    alu_req    = 1'b0;
    alu_ai     = 8'h00;
    alu_bi     = 8'h00;
    alu_ci     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_LO;
      end
      S_LO: begin
        alu_req = 1'b1;
        alu_ai  = r_base[7:0];
        alu_bi  = r_off;
        if (alu_gnt) w_next = w_to_hi ? S_HI : S_DONE;
      end
      S_HI: begin
        alu_req = 1'b1;
        alu_ai  = r_base[15:8];
        alu_bi  = w_dec ? 8'hFF : 8'h00;
        alu_ci  = w_inc;
        if (alu_gnt) w_next = S_DONE;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base   <= 16'h0000;
      r_off    <= 8'h00;
      r_signed <= 1'b0;
      r_lo     <= 8'h00;
      r_c      <= 1'b0;
      r_addr   <= 16'h0000;
      r_cross  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_base   <= req_base;
          r_off    <= req_off;
          r_signed <= req_signed;
        end
        S_LO: if (alu_gnt) begin
          r_lo <= alu_out;
          r_c  <= alu_c;
          if (!w_to_hi) begin
            r_addr  <= {r_base[15:8], alu_out};
            r_cross <= 1'b0;
          end
        end
        S_HI: if (alu_gnt) begin
          // High-byte carry out is dropped: the address wraps within 16 bits.
          r_addr  <= {alu_out, r_lo};
          r_cross <= w_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_addr_seq.sv
// Self-checking bench for alu_addr_seq: directed cases plus randomized requests vs. an arithmetic model.
module tb_alu_addr_seq;

`ifdef ALU_SEQ_FORCE_HI_EN
  localparam bit FORCE = 1'b1;
`else
  localparam bit FORCE = 1'b0;
`endif
  localparam logic [2:0] TB_ADD = 3'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [15:0] req_base = 16'h0;
  logic [7:0]  req_off = 8'h0;
  logic        req_signed = 1'b0;
  logic        resp_valid, resp_ready = 1'b0;
  logic [15:0] resp_addr;
  logic        resp_cross;
  logic        alu_req, alu_gnt = 1'b0;
  logic [7:0]  alu_ai, alu_bi, alu_out;
  logic        alu_ci, alu_c;
  logic [2:0]  alu_op;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Shared-ALU stand-in: plain 8-bit add with carry.
  assign {alu_c, alu_out} = {1'b0, alu_ai} + {1'b0, alu_bi} + {8'h00, alu_ci};

  alu_addr_seq #(.ADD_OP(TB_ADD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_off(req_off), .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_addr(resp_addr), .resp_cross(resp_cross),
    .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_ci(alu_ci), .alu_op(alu_op),
    .alu_out(alu_out), .alu_c(alu_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_resp_addr", 32'(resp_addr), 32'(0));
    chk("rst_resp_cross", 32'(resp_cross), 32'(0));
    chk("rst_alu_req", 32'(alu_req), 32'(0));
    chk("rst_alu_ai", 32'(alu_ai), 32'(0));
    chk("rst_alu_bi", 32'(alu_bi), 32'(0));
    chk("rst_alu_ci", 32'(alu_ci), 32'(0));
    chk("rst_alu_op", 32'(alu_op), 32'(TB_ADD));
  endtask

  // One request end to end. stall: forced-low grant cycles first; rnd: random grant afterwards;
  // hold: cycles resp_ready stays low once the result is up.
  task automatic run(input logic [15:0] b, input logic [7:0] o, input logic s,
                     input int stall, input bit rnd, input int hold);
    logic [15:0] ea;
    logic        ng, cr, inc, dec;
    int          lat, lows, ph, n, exp_lat;
    ng  = s & o[7];
    ea  = b + (ng ? {8'hFF, o} : {8'h00, o});
    cr  = (ea[15:8] != b[15:8]);
    dec = cr & ng;
    inc = cr & ~ng;
    chk("idle_req_ready", 32'(req_ready), 32'(1));
    req_valid = 1'b1; req_base = b; req_off = o; req_signed = s;
    tick();
    req_valid = 1'b0; req_base = 16'($urandom); req_off = 8'($urandom); req_signed = 1'($urandom);
    lat = 1; lows = 0; ph = 0; n = 0;
    while (!resp_valid && n < 60) begin
      chk("busy_req_ready", 32'(req_ready), 32'(0));
      chk("busy_alu_req", 32'(alu_req), 32'(1));
      chk("busy_alu_op", 32'(alu_op), 32'(TB_ADD));
      if (ph == 0) begin
        chk("lo_ai", 32'(alu_ai), 32'(b[7:0]));
        chk("lo_bi", 32'(alu_bi), 32'(o));
        chk("lo_ci", 32'(alu_ci), 32'(0));
      end else begin
        chk("hi_ai", 32'(alu_ai), 32'(b[15:8]));
        chk("hi_bi", 32'(alu_bi), dec ? 32'hFF : 32'h00);
        chk("hi_ci", 32'(alu_ci), 32'(inc));
      end
      alu_gnt = (n < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (alu_gnt) ph++; else lows++;
      tick();
      lat++; n++;
    end
    alu_gnt = 1'b0;
    chk("resp_timeout", 32'(resp_valid), 32'(1));
    exp_lat = (FORCE ? 3 : (cr ? 3 : 2)) + lows;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("done_alu_req", 32'(alu_req), 32'(0));
    chk("done_alu_ops", {alu_ai, alu_bi, 7'd0, alu_ci}, 32'(0));
    chk("resp_addr", 32'(resp_addr), 32'(ea));
    chk("resp_cross", 32'(resp_cross), 32'(cr));
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_valid", 32'(resp_valid), 32'(1));
      chk("hold_req_ready", 32'(req_ready), 32'(0));
      chk("hold_addr", {15'd0, resp_cross, resp_addr}, {15'd0, cr, ea});
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("post_resp_valid", 32'(resp_valid), 32'(0));
    chk("post_req_ready", 32'(req_ready), 32'(1));
  endtask

  initial begin
    tick(); tick();
    chk_reset_vals();
    rst_n = 1'b1;
    tick();
    chk_reset_vals();

    run(16'h12F0, 8'h05, 1'b0, 0, 1'b0, 0);   // no cross
    run(16'h12F0, 8'h20, 1'b0, 0, 1'b0, 0);   // carry into high byte
    run(16'h2005, 8'hFA, 1'b1, 0, 1'b0, 0);   // borrow from high byte
    run(16'h2010, 8'hF0, 1'b1, 0, 1'b0, 0);   // negative, stays in page
    run(16'hFFFF, 8'h01, 1'b0, 0, 1'b0, 0);   // high-byte wrap up
    run(16'h0000, 8'hFF, 1'b1, 0, 1'b0, 0);   // high-byte wrap down
    run(16'h12F0, 8'h05, 1'b0, 3, 1'b0, 2);   // grant stalls and response backpressure
    run(16'h34FF, 8'h80, 1'b0, 0, 1'b0, 1);   // unsigned 0x80 is not negative

    // Abort in the high-byte cycle: outputs drop to reset values without a clock edge.
    req_valid = 1'b1; req_base = 16'h12F0; req_off = 8'h20; req_signed = 1'b0;
    tick();
    req_valid = 1'b0;
    alu_gnt = 1'b1;
    tick();
    alu_gnt = 1'b0;
    chk("abort_in_hi", {alu_req, 23'd0, alu_ai}, {1'b1, 23'd0, 8'h12});
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    tick();
    rst_n = 1'b1;
    tick();
    run(16'h12F0, 8'h05, 1'b0, 0, 1'b0, 0);

    for (int i = 0; i < 40; i++)
      run(16'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b1,
          int'($urandom_range(0, 2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
